// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter that shares one memory port between instruction-fetch and data requesters.
module mem_bus_arbiter #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iresp_addr_ok,
  output logic              iresp_data_ok,
  output logic [31:0]       iresp_data,
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [2:0]        dreq_size,
  input  logic [7:0]        dreq_strobe,
  input  logic [63:0]       dreq_data,
  output logic              dresp_addr_ok,
  output logic              dresp_data_ok,
  output logic [63:0]       dresp_data,
  output logic              mreq_valid,
  output logic [ADDR_W-1:0] mreq_addr,
  output logic [2:0]        mreq_size,
  output logic [7:0]        mreq_strobe,
  output logic [63:0]       mreq_data,
  input  logic              mresp_addr_ok,
  input  logic              mresp_data_ok,
  input  logic [63:0]       mresp_data,
  output logic              busy
);
  localparam logic [2:0] MSIZE4 = 3'd2;
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
  state_t state, state_n;
  logic last_d, addr_seen, grant_i, grant_d, act_i, act_d;
  logic [ADDR_W-1:0] buf_addr;
  logic [2:0] buf_size;
  logic [7:0] buf_strobe;
  logic [63:0] buf_data;
  always_comb begin
    grant_d = (state == IDLE) && dreq_valid && !(ireq_valid && last_d);
    grant_i = (state == IDLE) && ireq_valid && !grant_d;
    state_n = grant_d ? GRANT_D : grant_i ? GRANT_I : (state != IDLE && mresp_data_ok) ? IDLE : state;
    // responses are only ever routed to the current owner, and never while reset is held
    act_i = !reset && state == GRANT_I;
    act_d = !reset && state == GRANT_D;
    iresp_addr_ok = act_i && mresp_addr_ok && !addr_seen;
    iresp_data_ok = act_i && mresp_data_ok;
    dresp_addr_ok = act_d && mresp_addr_ok && !addr_seen;
    dresp_data_ok = act_d && mresp_data_ok;
    iresp_data = buf_addr[2] ? mresp_data[63:32] : mresp_data[31:0];
    dresp_data = mresp_data;
    busy = state != IDLE;
    mreq_valid = state != IDLE;
    mreq_addr = buf_addr;
    mreq_size = buf_size;
    mreq_strobe = buf_strobe;
    mreq_data = buf_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_d <= 1'b0;
      addr_seen <= 1'b0;
      buf_addr <= '0;
      buf_size <= '0;
      buf_strobe <= '0;
      buf_data <= '0;
    end else begin
      state <= state_n;
      addr_seen <= (state != IDLE) && !mresp_data_ok && (addr_seen || mresp_addr_ok);
      if (grant_i || grant_d) begin
        last_d <= grant_d;
        buf_addr <= grant_d ? dreq_addr : ireq_addr;
        buf_size <= grant_d ? dreq_size : MSIZE4;
        buf_strobe <= grant_d ? dreq_strobe : 8'h00;
        buf_data <= grant_d ? dreq_data : 64'h0;
      end
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: table, directed and randomized checks of mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;
  logic clk, reset, ireq_valid, dreq_valid, mresp_addr_ok, mresp_data_ok;
  logic [63:0] ireq_addr, dreq_addr, dreq_data, mresp_data;
  logic [2:0] dreq_size;
  logic [7:0] dreq_strobe;
  logic iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok, mreq_valid, busy;
  logic [31:0] iresp_data;
  logic [63:0] dresp_data, mreq_addr, mreq_data;
  logic [2:0] mreq_size;
  logic [7:0] mreq_strobe;
  int n_cmp = 0, n_bad = 0;
  bit chk = 0;
  int own;
  bit m_last, m_seen;
  logic [63:0] m_addr, m_data;
  logic [2:0] m_size;
  logic [7:0] m_strobe;
  typedef struct packed {logic iv, dv, aok, dok; logic [5:0] exp;} vec_t;
  vec_t tbl [9];

  mem_bus_arbiter #(.ADDR_W(64)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .mreq_valid(mreq_valid), .mreq_addr(mreq_addr), .mreq_size(mreq_size),
    .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
    .mresp_addr_ok(mresp_addr_ok), .mresp_data_ok(mresp_data_ok), .mresp_data(mresp_data),
    .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    own = 0; m_last = 0; m_seen = 0;
    m_addr = 0; m_data = 0; m_size = 0; m_strobe = 0;
  endtask

  task automatic model_check();
    bit ia, id, da, dd;
    ia = !reset && own == 1 && mresp_addr_ok && !m_seen;
    id = !reset && own == 1 && mresp_data_ok;
    da = !reset && own == 2 && mresp_addr_ok && !m_seen;
    dd = !reset && own == 2 && mresp_data_ok;
    check("ctl", {58'd0, mreq_valid, busy, iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok},
          {58'd0, own != 0, own != 0, ia, id, da, dd});
    if (own != 0) begin
      check("maddr", mreq_addr, m_addr);
      check("mdata", mreq_data, m_data);
      check("msize_strobe", {53'd0, mreq_size, mreq_strobe}, {53'd0, m_size, m_strobe});
    end
    if (id) check("idata", {32'd0, iresp_data}, {32'd0, m_addr[2] ? mresp_data[63:32] : mresp_data[31:0]});
    if (dd) check("ddata", dresp_data, mresp_data);
  endtask

  task automatic model_update();
    if (reset) model_reset();
    else if (own == 0) begin
      if (ireq_valid && dreq_valid) own = m_last ? 1 : 2;
      else if (dreq_valid) own = 2;
      else if (ireq_valid) own = 1;
      if (own == 2) begin
        m_addr = dreq_addr; m_size = dreq_size; m_strobe = dreq_strobe; m_data = dreq_data; m_last = 1;
      end else if (own == 1) begin
        m_addr = ireq_addr; m_size = 3'd2; m_strobe = 0; m_data = 0; m_last = 0;
      end
    end else if (mresp_data_ok) begin
      own = 0; m_seen = 0;
    end else if (mresp_addr_ok) m_seen = 1;
  endtask

  task automatic cycle();
    #1;
    if (chk) model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    ireq_valid = 0; dreq_valid = 0; mresp_addr_ok = 0; mresp_data_ok = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    model_reset();
    #1 reset = 0;
    #1;
    check("reset_state", {62'd0, mreq_valid, busy}, 64'd0);
  endtask

  initial begin
    reset = 1; idle_inputs();
    ireq_addr = 64'h8000_0004; dreq_addr = 64'h8000_0008;
    dreq_size = 3'd3; dreq_strobe = 8'h0F; dreq_data = 64'h0123_4567_89AB_CDEF;
    mresp_data = 64'hAAAA_BBBB_CCCC_DDDD;
    model_reset();
    do_reset();
    chk = 1;
    // {iv,dv,aok,dok} -> {mreq_valid,busy,iaok,idok,daok,ddok}
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000000};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'b110010};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'b110000};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 6'b110001};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000000};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'b111100};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'b000000};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b110001};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    for (int i = 0; i < 9; i++) begin
      ireq_valid = tbl[i].iv; dreq_valid = tbl[i].dv;
      mresp_addr_ok = tbl[i].aok; mresp_data_ok = tbl[i].dok;
      #1;
      check($sformatf("tbl%0d", i),
            {58'd0, mreq_valid, busy, iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok},
            {58'd0, tbl[i].exp});
      if (i == 5) check("tbl_i_size_strobe", {53'd0, mreq_size, mreq_strobe}, {53'd0, 3'd2, 8'h00});
      cycle();
    end

    // single D store with data_ok three cycles after the request
    do_reset();
    dreq_valid = 1; dreq_addr = 64'h8000_0008; dreq_size = 3'd3; dreq_strobe = 8'hFF;
    dreq_data = 64'h1122_3344_5566_7788;
    cycle();
    dreq_valid = 0;
    #1;
    check("st_valid", {63'd0, mreq_valid}, 64'd1);
    check("st_addr", mreq_addr, 64'h8000_0008);
    check("st_data", mreq_data, 64'h1122_3344_5566_7788);
    check("st_size_strobe", {53'd0, mreq_size, mreq_strobe}, {53'd0, 3'd3, 8'hFF});
    cycle(); cycle();
    mresp_data_ok = 1; mresp_data = 64'h0;
    #1;
    check("st_dok", {63'd0, dresp_data_ok}, 64'd1);
    cycle();
    mresp_data_ok = 0;
    #1;
    check("st_after", {61'd0, mreq_valid, busy, dresp_data_ok}, 64'd0);

    // ifetch word select by address bit 2
    mresp_data = 64'hAAAA_BBBB_CCCC_DDDD;
    ireq_valid = 1; ireq_addr = 64'h8000_0004;
    cycle();
    ireq_valid = 0; mresp_data_ok = 1;
    #1;
    check("if_hi", {32'd0, iresp_data}, 64'hAAAA_BBBB);
    cycle();
    mresp_data_ok = 0; ireq_valid = 1; ireq_addr = 64'h8000_0000;
    cycle();
    ireq_valid = 0; mresp_data_ok = 1;
    #1;
    check("if_lo", {32'd0, iresp_data}, 64'hCCCC_DDDD);
    cycle();
    mresp_data_ok = 0;

    // D drops valid mid-transaction, request buffer must hold
    dreq_valid = 1; dreq_addr = 64'h8000_1230;
    cycle();
    dreq_valid = 0; dreq_addr = 64'hDEAD_0000;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("drop_hold", {mreq_valid, mreq_addr[62:0]}, {1'b1, 63'h8000_1230});
      check("drop_i_quiet", {62'd0, iresp_addr_ok, iresp_data_ok}, 64'd0);
      cycle();
    end
    mresp_data_ok = 1;
    #1;
    check("drop_dok", {62'd0, dresp_data_ok, iresp_data_ok}, 64'd2);
    cycle();
    mresp_data_ok = 0;

    // reset inside GRANT_I with I still pending, then stray responses
    ireq_valid = 1; ireq_addr = 64'h8000_0040;
    cycle();
    reset = 1;
    cycle();
    reset = 0; ireq_valid = 0;
    #1;
    check("rst_idle", {62'd0, mreq_valid, busy}, 64'd0);
    mresp_addr_ok = 1; mresp_data_ok = 1;
    #1;
    check("rst_stray", {60'd0, iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok}, 64'd0);
    cycle();
    idle_inputs();
    cycle();

    // both ports continuously valid: grants alternate starting with D
    do_reset();
    ireq_valid = 1; dreq_valid = 1;
    for (int k = 0; k < 6; k++) begin
      mresp_data_ok = 0;
      cycle();
      mresp_data_ok = 1;
      #1;
      check($sformatf("rr%0d", k), {62'd0, dresp_data_ok, iresp_data_ok},
            (k % 2 == 0) ? 64'd2 : 64'd1);
      if (k % 2 == 1) check("rr_i_size_strobe", {53'd0, mreq_size, mreq_strobe}, {53'd0, 3'd2, 8'h00});
      cycle();
    end
    idle_inputs();
    cycle();

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      ireq_valid = $urandom_range(0, 1) == 1;
      dreq_valid = $urandom_range(0, 1) == 1;
      mresp_addr_ok = $urandom_range(0, 1) == 1;
      mresp_data_ok = $urandom_range(0, 2) == 0;
      ireq_addr = {32'h8000_0000, $urandom};
      dreq_addr = {32'h8000_0000, $urandom};
      dreq_size = 3'($urandom_range(0, 3));
      dreq_strobe = 8'($urandom);
      dreq_data = {$urandom, $urandom};
      mresp_data = {$urandom, $urandom};
      cycle();
    end
    reset = 0;
    idle_inputs();
    cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, the request address width.
REQ-002 SHALL have ports clk (in, 1, clock) and reset (in, 1, synchronous active-high reset); one clock domain only, all state updates on posedge clk.
REQ-003 SHALL have inputs ireq_valid (1) and ireq_addr (ADDR_W), the instruction-fetch request.
REQ-004 SHALL have outputs iresp_addr_ok (1), iresp_data_ok (1) and iresp_data (32), the instruction-fetch response.
REQ-005 SHALL have inputs dreq_valid (1), dreq_addr (ADDR_W), dreq_size (3, MSIZE1/2/4/8 encoding), dreq_strobe (8) and dreq_data (64), the data-memory request; strobe 0 means read.
REQ-006 SHALL have outputs dresp_addr_ok (1), dresp_data_ok (1) and dresp_data (64), the data-memory response.
REQ-007 SHALL have outputs mreq_valid (1), mreq_addr (ADDR_W), mreq_size (3), mreq_strobe (8) and mreq_data (64), the shared memory request.
REQ-008 SHALL have inputs mresp_addr_ok (1), mresp_data_ok (1) and mresp_data (64), the shared memory response.
REQ-009 SHALL have output busy (1), high in any non-IDLE state.

Function
REQ-010 SHALL implement the FSM states IDLE, GRANT_I and GRANT_D.
REQ-011 IDLE, exactly one requester valid: SHALL enter the matching GRANT state at the next edge.
REQ-012 IDLE, both valid: SHALL grant the requester not granted last (round-robin), using register last_d.
REQ-013 On grant, SHALL latch the winner's addr/size/strobe/data into a request buffer. Ifetch latches size=MSIZE4 and strobe=0. mreq_* SHALL be driven only from this buffer.
REQ-014 Arbitration latency SHALL be one cycle: valid seen in IDLE at cycle c gives mreq_valid=1 in cycle c+1.
REQ-015 In GRANT_x, mreq_valid SHALL be 1 until and including the cycle mresp_data_ok=1, then the FSM SHALL return to IDLE at that edge.
REQ-016 The cycle after data_ok SHALL be IDLE with mreq_valid=0, giving a minimum one-cycle turnaround between transactions.
REQ-017 The FSM SHALL record whether mresp_addr_ok has been seen, and SHALL forward addr_ok only once per transaction.
REQ-018 mresp_addr_ok/mresp_data_ok SHALL be forwarded combinationally only to the granted port; the other port's ok signals SHALL be 0.
REQ-019 In GRANT_I, iresp_data SHALL be mresp_data[31:0] when the latched addr[2]=0 and mresp_data[63:32] otherwise; in GRANT_D, dresp_data = mresp_data unmodified.
REQ-020 Requester valid dropping mid-transaction SHALL NOT abort or alter the memory transaction; the buffer holds until data_ok, and the response is still pulsed to that port.
REQ-021 A new valid on the non-granted port during GRANT_x SHALL wait, with no ok signals to it, and SHALL be arbitrated in the following IDLE cycle.
REQ-022 mresp_addr_ok and mresp_data_ok in the same cycle SHALL forward both and complete the transaction.
REQ-023 mresp_* asserted while IDLE SHALL be ignored, and no ok SHALL be forwarded.
REQ-024 last_d SHALL update at each grant: 1 for a D grant, 0 for an I grant.

Reset
REQ-025 reset=1 SHALL force IDLE, last_d=0, buffer=0, addr_ok-seen=0, and mreq_valid=busy=0 from the next cycle.
REQ-026 Reset mid-transaction SHALL abandon it with no response pulsed afterwards; mresp signals during or after reset SHALL be ignored until a new grant.
REQ-027 After reset deassertion, the first simultaneous request SHALL go to D, since last_d=0.

Verification
REQ-028 Single D store: addr 0x80000008, size MSIZE8, strobe 0xFF, data 0x1122334455667788 -> mreq matches one cycle later; mresp data_ok at +3 -> dresp_data_ok=1 that cycle only, IDLE next.
REQ-029 Simultaneous I and D after reset -> D granted first; after its data_ok, one IDLE cycle, then I granted with mreq_strobe=0 and mreq_size=MSIZE4.
REQ-030 Ifetch at 0x80000004, mresp_data=0xAAAABBBB_CCCCDDDD -> iresp_data=0xAAAABBBB; at 0x80000000 -> 0xCCCCDDDD.
REQ-031 D drops dreq_valid after grant, before data_ok -> mreq_valid stays 1 with unchanged addr until data_ok; dresp_data_ok pulses; iresp_* stays 0 throughout.
REQ-032 reset asserted in GRANT_I with I pending -> IDLE next cycle, mreq_valid=0; a later stray mresp_data_ok produces no iresp/dresp ok.
REQ-033 Both ports continuously valid for 6 transactions -> grants alternate D, I, D, I, D, I.
